router_pkt_framer: RTL

- Upstream stage of the router.
- Accepts a payload byte stream on a valid/ready handshake and buffers one packet.
- Prepends the 10-byte router header: SA, DA, 4-byte length, 4-byte CRC.
- Replays the framed packet on dut_inp/inp_valid, honouring the router's busy and its input-gap rules.

---
 rtl/router_pkt_framer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_framer.sv
// Buffers one payload packet, prepends the 10-byte router header (SA, DA, LEN, CRC) and replays it.
// Define ROUTER_FRAMER_BAD_CRC_EN to add inject_crc_err, which inverts the CRC byte of a packet.
module router_pkt_framer #(
   parameter int unsigned MAX_PAYLOAD = 1990,
   parameter int unsigned MIN_PAYLOAD = 2,
   parameter int unsigned IPG         = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   input  logic [7:0]  cfg_sa,
   input  logic [7:0]  cfg_da,
`ifdef ROUTER_FRAMER_BAD_CRC_EN
   input  logic        inject_crc_err,
`endif
   input  logic        busy,
   output logic [7:0]  dut_inp,
   output logic        inp_valid,
   output logic        drop_err,
   output logic [31:0] pkt_sent_count,
   output logic [31:0] pkt_drop_count
);

   localparam int unsigned PW = $clog2(MAX_PAYLOAD + 1);
   localparam int unsigned FW = $clog2(MAX_PAYLOAD + 11);
   localparam int unsigned GW = 4;

   typedef enum logic [2:0] {
      StIdle, StCollect, StDrain, StCheck, StDrop, StWait, StSend, StGap
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   wptr_q;
   logic [7:0]      sum_q, sa_q, da_q, dut_q;
   logic            crc_inv_q, drain_done_q;
   logic [FW-1:0]   tx_idx_q;
   logic [GW-1:0]   gap_q;
   logic [7:0]      buf_mem [MAX_PAYLOAD];

   logic            beat, wr_en, gap_ok, last_byte;
   logic [PW-1:0]   wr_addr, rd_addr;
   logic [FW-1:0]   tx_sel;
   logic [31:0]     frame_len;
   logic [7:0]      tx_byte;

   assign beat      = s_valid && s_ready;
   assign wr_en     = beat && ((state_q == StIdle) ||
                               (state_q == StCollect && wptr_q != PW'(MAX_PAYLOAD)));
   assign wr_addr   = (state_q == StIdle) ? '0 : wptr_q;
   assign frame_len = 32'(wptr_q) + 32'd10;
   assign gap_ok    = gap_q >= GW'(IPG);
   assign last_byte = 32'(tx_idx_q) == frame_len - 32'd1;
   // Index of the byte to be presented on the next cycle.
   assign tx_sel    = (state_q == StSend) ? tx_idx_q + FW'(1) : '0;
   assign rd_addr   = PW'(tx_sel - FW'(10));
   assign dut_inp   = inp_valid ? dut_q : 8'hzz;

   always_ff @(posedge clk) begin
      if (wr_en) buf_mem[wr_addr] <= s_data;
   end

   always_comb begin
      tx_byte = 8'h00;
      case (tx_sel)
         FW'(0):                 tx_byte = sa_q;
         FW'(1):                 tx_byte = da_q;
         FW'(2):                 tx_byte = frame_len[7:0];
         FW'(3):                 tx_byte = frame_len[15:8];
         FW'(4):                 tx_byte = frame_len[23:16];
         FW'(5):                 tx_byte = frame_len[31:24];
         FW'(6):                 tx_byte = crc_inv_q ? ~sum_q : sum_q;
         FW'(7), FW'(8), FW'(9): tx_byte = 8'h00;
         default:                tx_byte = buf_mem[rd_addr];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         s_ready        <= 1'b0;
         inp_valid      <= 1'b0;
         dut_q          <= 8'h00;
         drop_err       <= 1'b0;
         pkt_sent_count <= '0;
         pkt_drop_count <= '0;
         wptr_q         <= '0;
         sum_q          <= 8'h00;
         sa_q           <= 8'h00;
         da_q           <= 8'h00;
         crc_inv_q      <= 1'b0;
         drain_done_q   <= 1'b0;
         tx_idx_q       <= '0;
         gap_q          <= GW'(IPG);
      end else begin
         drop_err <= 1'b0;
         if (state_q == StSend) gap_q <= '0;
         else if (!gap_ok)      gap_q <= gap_q + GW'(1);

         unique case (state_q)
            StIdle: begin
               s_ready <= 1'b1;
               if (beat) begin
                  sa_q   <= cfg_sa;
                  da_q   <= cfg_da;
`ifdef ROUTER_FRAMER_BAD_CRC_EN
                  crc_inv_q <= inject_crc_err;
`else
                  crc_inv_q <= 1'b0;
`endif
                  sum_q  <= s_data;
                  wptr_q <= PW'(1);
                  if (s_last) begin
                     state_q <= StCheck;
                     s_ready <= 1'b0;
                  end else begin
                     state_q <= StCollect;
                  end
               end
            end
            StCollect: begin
               if (beat) begin
                  if (wptr_q == PW'(MAX_PAYLOAD)) begin
                     // Overflow beat is dropped; if it was also last there is nothing left to drain.
                     state_q      <= StDrain;
                     drain_done_q <= s_last;
                     s_ready      <= !s_last;
                  end else begin
                     wptr_q <= wptr_q + PW'(1);
                     sum_q  <= sum_q + s_data;
                     if (s_last) begin
                        state_q <= StCheck;
                        s_ready <= 1'b0;
                     end
                  end
               end
            end
            StDrain: begin
               if (drain_done_q || (beat && s_last)) begin
                  state_q        <= StDrop;
                  s_ready        <= 1'b0;
                  drop_err       <= 1'b1;
                  pkt_drop_count <= pkt_drop_count + 32'd1;
               end
            end
            StCheck: begin
               if (wptr_q < PW'(MIN_PAYLOAD)) begin
                  state_q        <= StDrop;
                  drop_err       <= 1'b1;
                  pkt_drop_count <= pkt_drop_count + 32'd1;
               end else begin
                  state_q <= StWait;
               end
            end
            StDrop: begin
               state_q      <= StIdle;
               s_ready      <= 1'b1;
               wptr_q       <= '0;
               sum_q        <= 8'h00;
               drain_done_q <= 1'b0;
            end
            StWait: begin
               if (!busy && gap_ok) begin
                  state_q   <= StSend;
                  inp_valid <= 1'b1;
                  dut_q     <= tx_byte;
                  tx_idx_q  <= '0;
               end
            end
            StSend: begin
               if (last_byte) begin
                  state_q        <= StGap;
                  inp_valid      <= 1'b0;
                  pkt_sent_count <= pkt_sent_count + 32'd1;
               end else begin
                  tx_idx_q <= tx_idx_q + FW'(1);
                  dut_q    <= tx_byte;
               end
            end
            StGap: begin
               state_q <= StIdle;
               s_ready <= 1'b1;
               wptr_q  <= '0;
               sum_q   <= 8'h00;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
